rr_mux_arbiter: RTL and testbench

Four-requester round-robin arbiter with valid/ready handshake that picks one requester per cycle, steers that requester's data through a 4:1 selection and registers the result in a single output stage. Sits directly upstream of the 4-input mux datapath: its `sel` output is the mux select, and its registered output is the consumer-facing stream. Guarantees fairness across the four sources and one-transfer-per-cycle throughput.

---
 rtl/rr_mux_pkg.sv | 19 +
 rtl/rr_mux_arbiter_rr_pick.sv | 29 ++
 rtl/rr_mux_arbiter.sv | 100 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
// No logic of its own; constants, the FSM state type and pointer increment.
// No flow control here; see rr_mux_arbiter for the handshake.
package rr_mux_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next requester after idx, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Rotating priority encoder: first set req bit scanning from prio upward, mod 4.
// Purely combinational, zero latency.
// No flow control; the caller gates the grant with its own load enable.
module rr_pick
  import rr_mux_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] prio,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Scan prio, prio+1, ... and keep the first requester found.
  always_comb begin
    any  = 1'b0;
    idx  = prio;
    cand = prio;
    for (int i = 0; i < NREQ; i++) begin
      cand = prio + IDX_W'(i);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter steering the winner's data into one output register.
// Latency: word accepted in cycle N is on out_data with out_valid in cycle N+1.
// Backpressure: in_ready only when the output register is empty or draining; optional
// burst lock (in_last) enabled by defining RR_MUX_LOCK_EN.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         in_valid,
  input  logic [NREQ-1:0][W-1:0]  in_data,
  input  logic [NREQ-1:0]         in_last,
  output logic [NREQ-1:0]         in_ready,
  output logic [IDX_W-1:0]        sel,
  output logic                    out_valid,
  output logic [W-1:0]            out_data,
  output logic [IDX_W-1:0]        out_src,
  input  logic                    out_ready
);

  state_t           state;
  logic [IDX_W-1:0] prio;
  logic [IDX_W-1:0] lock_id;
  logic [IDX_W-1:0] sel_q;
  logic [NREQ-1:0]  elig;
  logic             any;
  logic [IDX_W-1:0] win;
  logic             load_en;
  logic             xfer;

`ifndef RR_MUX_LOCK_EN
  // Burst markers only matter when locking is built in.
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  assign load_en = !out_valid || out_ready;

  // While locked only the burst owner may compete; in ARB everyone may.
  always_comb begin
    elig = in_valid;
    if (state == LOCKED) elig = in_valid & (NREQ'(1) << lock_id);
  end

  rr_pick u_pick (
    .req  (elig),
    .prio (prio),
    .any  (any),
    .idx  (win)
  );

  assign xfer = reset_n && any && load_en;

  // Grant is one-hot to the winner, and never while in reset.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[win] = 1'b1;
  end

  // Mux select follows the live winner, otherwise the last granted index.
  always_comb begin
    sel = sel_q;
    if (!reset_n)  sel = '0;
    else if (any)  sel = win;
  end

  // Output register, priority pointer and lock FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      prio      <= '0;
      lock_id   <= '0;
      sel_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[win];
      out_src   <= win;
      sel_q     <= win;
`ifdef RR_MUX_LOCK_EN
      if (in_last[win]) begin
        state <= ARB;
        prio  <= rr_next(win);
      end else begin
        state   <= LOCKED;
        lock_id <= win;
      end
`else
      prio <= rr_next(win);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Expectations for the burst test follow whether RR_MUX_LOCK_EN is defined.
module tb_rr_mux_arbiter;

  localparam int W = 4;

  logic             clk;
  logic             reset_n;
  logic [3:0]       in_valid;
  logic [3:0][W-1:0] in_data;
  logic [3:0]       in_last;
  logic [3:0]       in_ready;
  logic [1:0]       sel;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_src;
  logic             out_ready;

  int n_total = 0;
  int n_pass  = 0;

  rr_mux_arbiter #(.W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_abcd();
    in_data[0] = 4'hA;
    in_data[1] = 4'hB;
    in_data[2] = 4'hC;
    in_data[3] = 4'hD;
  endtask

  int exp_src1 [5] = '{0, 1, 2, 3, 0};
  int exp_dat1 [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
`ifdef RR_MUX_LOCK_EN
  int exp_src5 [4] = '{1, 1, 1, 3};
  int exp_dat5 [4] = '{1, 2, 3, 9};
`else
  int exp_src5 [4] = '{1, 3, 1, 3};
  int exp_dat5 [4] = '{1, 9, 2, 9};
`endif

  initial begin
    int   w1;
    logic g1;
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = 4'hF;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_src",   out_src,   0);
    chk("rst_sel",       sel,       0);
    chk("rst_in_ready",  in_ready,  0);

    // Full contention: strict rotation 0,1,2,3,0.
    @(negedge clk);
    reset_n   = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    load_abcd();
    #1;
    chk("rr_sel0", sel, 0);
    for (int k = 0; k < 5; k++) begin
      chk("rr_in_ready", in_ready, 32'(1) << exp_src1[k]);
      tick();
      chk("rr_out_valid", out_valid, 1);
      chk("rr_out_src",   out_src,   exp_src1[k]);
      chk("rr_out_data",  out_data,  exp_dat1[k]);
    end

    // Lone requester 2 wins every cycle.
    in_valid   = 4'b0100;
    in_data[2] = 4'h5;
    #1;
    chk("solo_sel", sel, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("solo_out_src",  out_src,  2);
      chk("solo_out_data", out_data, 5);
      chk("solo_in_ready", in_ready, 4'b0100);
    end

    // Stall with full output, then drain and load in the same cycle.
    out_ready = 1'b0;
    in_valid  = 4'hF;
    load_abcd();
    #1;
    chk("stall_in_ready", in_ready, 0);
    chk("stall_sel_prio3", sel, 3);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data",  out_data,  5);
      chk("stall_out_src",   out_src,   2);
    end
    out_ready = 1'b1;
    #1;
    chk("resume_in_ready", in_ready, 4'b1000);
    tick();
    chk("resume_out_valid", out_valid, 1);
    chk("resume_out_data",  out_data,  4'hD);
    chk("resume_out_src",   out_src,   3);
    in_valid = '0;
    #1;
    chk("idle_sel_hold", sel, 3);
    chk("idle_in_ready", in_ready, 0);
    tick();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_out_data",  out_data,  4'hD);

    // Reset while holding a word clears everything without a clock edge.
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_out_src",   out_src,   1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_src",   out_src,   0);
    chk("mid_rst_sel",       sel,       0);
    chk("mid_rst_in_ready",  in_ready,  0);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 4'b0001);
    tick();
    chk("post_rst_out_src",  out_src,  0);
    chk("post_rst_out_data", out_data, 4'hA);

    // Requester 1 sends a three-word burst while requester 3 keeps asking.
    w1 = 0;
    in_data[3] = 4'h9;
    for (int k = 0; k < 4; k++) begin
      in_valid   = {1'b1, 1'b0, (w1 < 3), 1'b0};
      in_data[1] = 4'(w1 + 1);
      in_last    = {1'b1, 1'b0, (w1 == 2), 1'b0};
      #1;
      g1 = in_ready[1];
      tick();
      chk("burst_out_src",  out_src,  exp_src5[k]);
      chk("burst_out_data", out_data, exp_dat5[k]);
      if (g1) w1++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
